mpc_coef_ram_writer: RTL and testbench

MPC_COEF_RAM_WRITER -- requirements
Module: mpc_coef_ram_writer

---
 rtl/mpc_coef_ram_writer.sv | 90 +++++++++
 tb/tb_mpc_coef_ram_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_coef_ram_writer.sv
// Coefficient RAM: an FSM loads AddressRange words from a valid/ready stream; an independent port reads them back.
// Latency: one cycle from ce0 to q0; writes land on the accepting edge. Backpressure: s_ready is high only while loading.
module mpc_coef_ram_writer #(
    parameter int DataWidth    = 14,
    parameter int AddressWidth = 3,
    parameter int AddressRange = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DataWidth-1:0]    s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [AddressWidth-1:0] address0,
    input  logic                    ce0,
    output logic [DataWidth-1:0]    q0,
    output logic                    loaded,
    output logic                    busy,
    output logic [AddressWidth-1:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [AddressWidth-1:0] wr_count_nxt;
    logic                    loaded_nxt;
    logic                    wr_en;

    logic [DataWidth-1:0]    mem [AddressRange];

    // start wins over a same-cycle beat, so a restart never writes the stale word
    always_comb begin
        state_nxt    = state;
        wr_count_nxt = wr_count;
        loaded_nxt   = loaded;
        wr_en        = 1'b0;
        if (start) begin
            state_nxt    = LOAD;
            wr_count_nxt = '0;
            loaded_nxt   = 1'b0;
        end else if (state == LOAD && s_valid) begin
            wr_en = 1'b1;
            if (wr_count == LastAddr) begin
                state_nxt  = DONE;
                loaded_nxt = 1'b1;
            end else begin
                wr_count_nxt = wr_count + AddressWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_count <= '0;
            loaded   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_count <= wr_count_nxt;
            loaded   <= loaded_nxt;
        end
    end

    assign s_ready = (state == LOAD);
    assign busy    = (state == LOAD);

    // Contents survive reset; only the load path may overwrite them
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_count] <= s_data;
        end
    end

    // Read-first: a same-cycle write to address0 is seen on the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            q0 <= '0;
        end else if (ce0) begin
            q0 <= (address0 <= LastAddr) ? mem[address0] : '0;
        end
    end

endmodule

// File: tb/tb_mpc_coef_ram_writer.sv
// Directed bench for mpc_coef_ram_writer: stimulus pushes expected values into a scoreboard, a negedge monitor checks them.
module tb_mpc_coef_ram_writer;

    localparam int DW = 14;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] address0;
    logic          ce0;
    logic [DW-1:0] q0;
    logic          loaded;
    logic          busy;
    logic [AW-1:0] wr_count;

    mpc_coef_ram_writer #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .address0 (address0),
        .ce0      (ce0),
        .q0       (q0),
        .loaded   (loaded),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        string         name;
        int            sig;
        logic [DW-1:0] val;
    } exp_t;

    localparam int SigQ0 = 0, SigLoaded = 1, SigBusy = 2, SigCount = 3, SigReady = 4;

    exp_t          sb[$];
    int            cyc = 0;
    int            applied = 0;
    int            miscompares = 0;
    logic          final_chk = 1'b0;
    logic          final_done = 1'b0;
    exp_t          e;
    logic [DW-1:0] act;
    logic [DW-1:0] w [6];

    always @(posedge clk) cyc++;

    // Monitor: compares every expectation whose cycle has been reached
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sig)
                SigQ0:     act = q0;
                SigLoaded: act = DW'(loaded);
                SigBusy:   act = DW'(busy);
                SigCount:  act = DW'(wr_count);
                default:   act = DW'(s_ready);
            endcase
            applied++;
            if (act !== e.val) begin
                miscompares++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, e.cyc, act, e.val);
            end
        end
        if (final_chk && !final_done) begin
            applied++;
            if (sb.size() != 0) begin
                miscompares++;
                $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
            end
            final_done = 1'b1;
        end
    end

    function automatic void chk(string n, int sig, logic [DW-1:0] v);
        exp_t x;
        x.cyc  = cyc + 1;
        x.name = n;
        x.sig  = sig;
        x.val  = v;
        sb.push_back(x);
    endfunction

    function automatic void chk_st(string n, logic ld, logic bz, logic [AW-1:0] wc);
        chk({n, ".loaded"},   SigLoaded, DW'(ld));
        chk({n, ".busy"},     SigBusy,   DW'(bz));
        chk({n, ".s_ready"},  SigReady,  DW'(bz));
        chk({n, ".wr_count"}, SigCount,  DW'(wc));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic st, logic v, logic [DW-1:0] d, logic ce, logic [AW-1:0] a);
        start    = st;
        s_valid  = v;
        s_data   = d;
        ce0      = ce;
        address0 = a;
    endtask

    task automatic rd(string n, logic [AW-1:0] a, logic [DW-1:0] v);
        set_in(1'b0, 1'b0, '0, 1'b1, a);
        chk(n, SigQ0, v);
        tick();
    endtask

    task automatic do_start(string n);
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        chk_st(n, 1'b0, 1'b1, '0);
        tick();
    endtask

    task automatic beat(string n, logic [DW-1:0] d, logic ld, logic bz, logic [AW-1:0] wc);
        set_in(1'b0, 1'b1, d, 1'b0, '0);
        chk_st(n, ld, bz, wc);
        tick();
    endtask

    initial begin
        w[0] = 14'h2D44; w[1] = 14'h00A6; w[2] = 14'h2005;
        w[3] = 14'h011C; w[4] = 14'h16A5; w[5] = 14'h016F;
        reset = 1'b1;
        set_in(1'b0, 1'b0, '0, 1'b0, '0);
        tick();

        // Reset state, with start/ce0 asserted to show reset dominates
        set_in(1'b1, 1'b1, 14'h3FFF, 1'b1, 3'd0);
        chk_st("reset", 1'b0, 1'b0, '0);
        chk("reset.q0", SigQ0, '0);
        tick();
        reset = 1'b0;
        set_in(1'b0, 1'b1, 14'h3FFF, 1'b0, '0);
        chk_st("idle_ignore", 1'b0, 1'b0, '0);
        tick();

        // Full back-to-back load
        do_start("full.start");
        for (int i = 0; i < 6; i++)
            beat("full.beat", w[i], i == 5, i != 5, (i == 5) ? AW'(5) : AW'(i + 1));
        set_in(1'b0, 1'b1, 14'h3FFF, 1'b0, '0);
        chk_st("done_ignore", 1'b1, 1'b0, AW'(5));
        tick();
        for (int k = 0; k < 6; k++) rd("full.rd", AW'(k), w[k]);

        // Read/write collision on address 2
        do_start("coll.start");
        beat("coll.b0", w[0], 1'b0, 1'b1, AW'(1));
        beat("coll.b1", w[1], 1'b0, 1'b1, AW'(2));
        set_in(1'b0, 1'b1, 14'h1111, 1'b1, 3'd2);
        chk("coll.old", SigQ0, 14'h2005);
        chk_st("coll.b2", 1'b0, 1'b1, AW'(3));
        tick();
        set_in(1'b0, 1'b0, '0, 1'b1, 3'd2);
        chk("coll.new", SigQ0, 14'h1111);
        tick();
        beat("coll.b3", w[3], 1'b0, 1'b1, AW'(4));
        beat("coll.b4", w[4], 1'b0, 1'b1, AW'(5));
        beat("coll.b5", w[5], 1'b1, 1'b0, AW'(5));

        // Gapped valid
        do_start("gap.start");
        for (int i = 0; i < 6; i++) begin
            beat("gap.beat", w[i], i == 5, i != 5, (i == 5) ? AW'(5) : AW'(i + 1));
            set_in(1'b0, 1'b0, '0, 1'b0, '0);
            chk_st("gap.idle", i == 5, i != 5, (i == 5) ? AW'(5) : AW'(i + 1));
            tick();
        end
        for (int k = 0; k < 6; k++) rd("gap.rd", AW'(k), w[k]);

        // Restart mid-load; the beat alongside start is dropped
        do_start("rs.start");
        beat("rs.b0", 14'h0AAA, 1'b0, 1'b1, AW'(1));
        beat("rs.b1", 14'h0BBB, 1'b0, 1'b1, AW'(2));
        beat("rs.b2", 14'h0CCC, 1'b0, 1'b1, AW'(3));
        set_in(1'b1, 1'b1, 14'h3FFF, 1'b0, '0);
        chk_st("rs.restart", 1'b0, 1'b1, '0);
        tick();
        for (int i = 0; i < 6; i++)
            beat("rs.beat", DW'(i + 1), i == 5, i != 5, (i == 5) ? AW'(5) : AW'(i + 1));
        for (int k = 0; k < 6; k++) rd("rs.rd", AW'(k), DW'(k + 1));

        // Out-of-range reads and hold with ce0 low
        rd("oor.a7", 3'd7, '0);
        rd("oor.a6", 3'd6, '0);
        rd("hold.load", 3'd3, 14'h0004);
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b0, '0, 1'b0, (k == 2) ? AW'(5) : AW'(k));
            chk("hold.q0", SigQ0, 14'h0004);
            tick();
        end

        // Reset mid-load, with start, a beat and a read all presented alongside it
        do_start("rst.start");
        for (int i = 0; i < 4; i++)
            beat("rst.beat", DW'((i + 1) * 14'h0111), 1'b0, 1'b1, AW'(i + 1));
        reset = 1'b1;
        set_in(1'b1, 1'b1, 14'h3FFF, 1'b1, 3'd1);
        chk_st("rst.mid", 1'b0, 1'b0, '0);
        chk("rst.q0", SigQ0, '0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b1, 14'h3FFF, 1'b0, '0);
            chk_st("rst.ignore", 1'b0, 1'b0, '0);
            tick();
        end
        for (int k = 0; k < 4; k++) rd("rst.rd", AW'(k), DW'((k + 1) * 14'h0111));
        rd("rst.rd4", 3'd4, 14'h0005);
        rd("rst.rd5", 3'd5, 14'h0006);

        set_in(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        final_chk = 1'b1;
        for (int i = 0; i < 5 && !final_done; i++) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
